// File: rtl/bcd_countdown_timer.sv
// bcd_countdown_timer
// Packed-BCD round clock for the puzzle game. The count steps down by one
// every TICK_CYCLES clocks while running. Load, start, pause and a saturating
// time penalty control it. It flags a warning zone and a one-cycle expiry
// pulse, then holds in EXPIRED until the next load or reset.
module bcd_countdown_timer #(
  parameter int unsigned DIGITS      = 2,
  parameter int unsigned TICK_CYCLES = 100000000,
  parameter logic [31:0] PENALTY     = 32'h0000_0005,
  parameter logic [31:0] WARN_LEVEL  = 32'h0000_0010
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   load_value,
  input  logic                  start,
  input  logic                  pause,
  input  logic                  penalty,
  output logic [4*DIGITS-1:0]   count,
  output logic                  running,
  output logic                  tick,
  output logic                  warn,
  output logic                  expired,
  output logic                  done
);

  localparam int unsigned   W          = 4 * DIGITS;
  localparam int unsigned   PW         = (TICK_CYCLES > 1) ? $clog2(TICK_CYCLES) : 1;
  localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_CYCLES - 1);
  localparam logic [PW-1:0] PRESC_ONE  = PW'(1);
  localparam logic [W-1:0]  PEN_C      = PENALTY[W-1:0];
  localparam logic [W-1:0]  WARN_C     = WARN_LEVEL[W-1:0];
  localparam logic [W-1:0]  ONE_C      = W'(1);
  localparam logic [W-1:0]  ZERO_C     = {W{1'b0}};

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RUN     = 2'd1,
    ST_PAUSED  = 2'd2,
    ST_EXPIRED = 2'd3
  } state_t;

  // Digit-serial BCD subtraction a - b. A borrow out of the top digit means
  // the true result is negative, so the result saturates to zero.
  function automatic logic [W-1:0] bcd_sub_sat(input logic [W-1:0] a,
                                               input logic [W-1:0] b);
    logic [W-1:0] diff;
    logic [4:0]   t;
    logic         borrow;
    diff   = {W{1'b0}};
    borrow = 1'b0;
    for (int i = 0; i < int'(DIGITS); i++) begin
      t = {1'b0, a[4*i +: 4]} - {1'b0, b[4*i +: 4]} - {4'b0000, borrow};
      if (t[4]) begin
        diff[4*i +: 4] = t[3:0] + 4'd10;
        borrow         = 1'b1;
      end else begin
        diff[4*i +: 4] = t[3:0];
        borrow         = 1'b0;
      end
    end
    if (borrow) begin
      return {W{1'b0}};
    end else begin
      return diff;
    end
  endfunction

  // Force every nibble into the legal BCD range 0..9. Any value above 9
  // becomes 9, so a garbage load still gives a sane maximum time.
  function automatic logic [W-1:0] bcd_clamp(input logic [W-1:0] v);
    logic [W-1:0] r;
    r = {W{1'b0}};
    for (int i = 0; i < int'(DIGITS); i++) begin
      if (v[4*i +: 4] > 4'd9) begin
        r[4*i +: 4] = 4'd9;
      end else begin
        r[4*i +: 4] = v[4*i +: 4];
      end
    end
    return r;
  endfunction

  state_t          r_state;
  logic [W-1:0]    r_count;
  logic [PW-1:0]   r_presc;
  logic            r_tick;
  logic            r_expired;

  state_t          w_state_next;
  logic [W-1:0]    w_count_next;
  logic [PW-1:0]   w_presc_next;
  logic            w_tick_next;
  logic            w_expired_next;
  logic            w_active;
  logic [W-1:0]    w_dec;
  logic [W-1:0]    w_pen;
  logic [W-1:0]    w_pen_tick;

  // Candidate count values. A penalty that lands on a tick cycle also takes
  // the one-step decrement, so both the penalty and the tick are applied.
  assign w_active   = (r_state == ST_RUN) || (r_state == ST_PAUSED);
  assign w_dec      = bcd_sub_sat(r_count, ONE_C);
  assign w_pen      = bcd_sub_sat(r_count, PEN_C);
  assign w_pen_tick = bcd_sub_sat(w_pen, ONE_C);

  // Next-state and next-datapath decode: load beats everything, pause beats start
  always_comb begin
    w_state_next   = r_state;
    w_count_next   = r_count;
    w_presc_next   = r_presc;
    w_tick_next    = 1'b0;
    w_expired_next = 1'b0;
    if (load) begin
      w_state_next = ST_IDLE;
      w_count_next = bcd_clamp(load_value);
      w_presc_next = {PW{1'b0}};
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start && (r_count != ZERO_C)) begin
            w_state_next = ST_RUN;
          end else begin
            w_state_next = ST_IDLE;
          end
        end
        ST_RUN: begin
          if (pause) begin
            w_state_next = ST_PAUSED;
          end else if (r_presc == PRESC_LAST) begin
            w_presc_next = {PW{1'b0}};
            w_tick_next  = 1'b1;
          end else begin
            w_presc_next = r_presc + PRESC_ONE;
          end
        end
        ST_PAUSED: begin
          if (pause) begin
            w_state_next = ST_PAUSED;
          end else if (start) begin
            w_state_next = ST_RUN;
          end else begin
            w_state_next = ST_PAUSED;
          end
        end
        ST_EXPIRED: begin
          w_state_next = ST_EXPIRED;
        end
        default: begin
          w_state_next = ST_IDLE;
        end
      endcase

      if (w_active && penalty) begin
        if (w_tick_next) begin
          w_count_next = w_pen_tick;
        end else begin
          w_count_next = w_pen;
        end
      end else if (w_tick_next) begin
        w_count_next = w_dec;
      end else begin
        w_count_next = r_count;
      end

      // Reaching zero from an active state expires the round in the same
      // cycle the zero is registered.
      if (w_active && (w_count_next == ZERO_C)) begin
        w_state_next   = ST_EXPIRED;
        w_expired_next = 1'b1;
        w_presc_next   = {PW{1'b0}};
      end else begin
        w_expired_next = 1'b0;
      end
    end
  end

  // State register with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Datapath registers: count, prescaler and the registered pulse outputs
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_count   <= {W{1'b0}};
      r_presc   <= {PW{1'b0}};
      r_tick    <= 1'b0;
      r_expired <= 1'b0;
    end else begin
      r_count   <= w_count_next;
      r_presc   <= w_presc_next;
      r_tick    <= w_tick_next;
      r_expired <= w_expired_next;
    end
  end

  // Output decode from the registered state and count
  always_comb begin
    running = (r_state == ST_RUN);
    done    = (r_state == ST_EXPIRED);
    if (w_active && (r_count != ZERO_C) && (r_count <= WARN_C)) begin
      warn = 1'b1;
    end else begin
      warn = 1'b0;
    end
  end

  assign count   = r_count;
  assign tick    = r_tick;
  assign expired = r_expired;

endmodule

// File: tb/tb_bcd_countdown_timer.sv
// tb_bcd_countdown_timer
// Directed stimulus for the BCD round clock. Each stimulus cycle pushes the
// hand-computed outputs expected after the coming clock edge into a queue.
// The monitor pops an entry and compares it once that edge has happened.
module tb_bcd_countdown_timer;

  logic       clk;
  logic       reset_n;
  logic       load;
  logic [7:0] load_value;
  logic       start;
  logic       pause;
  logic       penalty;
  logic [7:0] count;
  logic       running;
  logic       tick;
  logic       warn;
  logic       expired;
  logic       done;

  bcd_countdown_timer #(
    .DIGITS      (2),
    .TICK_CYCLES (4),
    .PENALTY     (32'h0000_0005),
    .WARN_LEVEL  (32'h0000_0003)
  ) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .load       (load),
    .load_value (load_value),
    .start      (start),
    .pause      (pause),
    .penalty    (penalty),
    .count      (count),
    .running    (running),
    .tick       (tick),
    .warn       (warn),
    .expired    (expired),
    .done       (done)
  );

  typedef struct {
    int unsigned edge_n;
    string       name;
    logic [7:0]  cnt;
    logic        run;
    logic        tck;
    logic        wrn;
    logic        exp;
    logic        dn;
  } exp_t;

  exp_t        sb_q[$];
  exp_t        mon_e;
  int unsigned n_edge;
  int          n_checks;
  int          n_err;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Count clock edges so expectations can be tied to a specific edge
  initial n_edge = 0;
  always @(posedge clk) n_edge <= n_edge + 1;

  // Monitor: compare every expectation whose edge has been reached
  always @(negedge clk) begin
    while (sb_q.size() > 0 && sb_q[0].edge_n <= n_edge) begin
      mon_e = sb_q.pop_front();
      n_checks = n_checks + 1;
      if (mon_e.edge_n != n_edge ||
          {count, running, tick, warn, expired, done} !==
          {mon_e.cnt, mon_e.run, mon_e.tck, mon_e.wrn, mon_e.exp, mon_e.dn}) begin
        n_err = n_err + 1;
        $display("FAIL %s @edge %0d: got cnt=%h run=%b tick=%b warn=%b exp=%b done=%b, want cnt=%h run=%b tick=%b warn=%b exp=%b done=%b (edge %0d)",
                 mon_e.name, n_edge, count, running, tick, warn, expired, done,
                 mon_e.cnt, mon_e.run, mon_e.tck, mon_e.wrn, mon_e.exp, mon_e.dn, mon_e.edge_n);
      end
    end
  end

  // One stimulus cycle: drive inputs, queue the expected post-edge outputs
  task automatic cy(input string nm, input logic l, input logic [7:0] lv,
                    input logic s, input logic p, input logic pn,
                    input logic [7:0] c, input logic r, input logic t,
                    input logic w, input logic x, input logic d);
    exp_t e;
    load       = l;
    load_value = lv;
    start      = s;
    pause      = p;
    penalty    = pn;
    e.edge_n = n_edge + 1;
    e.name   = nm;
    e.cnt    = c;
    e.run    = r;
    e.tck    = t;
    e.wrn    = w;
    e.exp    = x;
    e.dn     = d;
    sb_q.push_back(e);
    @(negedge clk);
  endtask

  // Three quiet RUN cycles followed by the tick that steps prev -> nxt
  task automatic seg(input string nm, input logic [7:0] prev, input logic wp,
                     input logic [7:0] nxt, input logic wn);
    for (int i = 0; i < 3; i++) begin
      cy(nm, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, prev, 1'b1, 1'b0, wp, 1'b0, 1'b0);
    end
    cy(nm, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, nxt, 1'b1, 1'b1, wn, 1'b0, 1'b0);
  endtask

  initial begin
    n_checks   = 0;
    n_err      = 0;
    reset_n    = 1'b0;
    load       = 1'b0;
    load_value = 8'h00;
    start      = 1'b0;
    pause      = 1'b0;
    penalty    = 1'b0;
    @(negedge clk);

    // Reset state
    cy("reset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;

    // 1: load 12, count down through a borrow
    cy("t1_load",  1'b1, 8'h12, 1'b0, 1'b0, 1'b0, 8'h12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cy("t1_start", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    seg("t1_12_11", 8'h12, 1'b0, 8'h11, 1'b0);
    seg("t1_11_10", 8'h11, 1'b0, 8'h10, 1'b0);
    seg("t1_10_09", 8'h10, 1'b0, 8'h09, 1'b0);

    // 2: expire by ticking, then start/penalty are ignored
    cy("t2_load",  1'b1, 8'h02, 1'b0, 1'b0, 1'b0, 8'h02, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cy("t2_start", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h02, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    seg("t2_02_01", 8'h02, 1'b1, 8'h01, 1'b1);
    for (int i = 0; i < 3; i++) begin
      cy("t2_wait", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h01, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    cy("t2_expire", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1);
    cy("t2_hold",   1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cy("t2_start",  1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    cy("t2_pen",    1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);

    // 3: pause with prescaler at 2, resume, tick two edges later
    cy("t3_load",  1'b1, 8'h12, 1'b0, 1'b0, 1'b0, 8'h12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cy("t3_start", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cy("t3_p1",    1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cy("t3_p2",    1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      cy("t3_pause", 1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h12, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    cy("t3_resume", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cy("t3_p3",     1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h12, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cy("t3_tick",   1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h11, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);

    // 4: penalties, warn boundary, penalty on a tick, penalty in IDLE/PAUSED
    cy("t4_load07", 1'b1, 8'h07, 1'b0, 1'b0, 1'b0, 8'h07, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cy("t4_start",  1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h07, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cy("t4_pen07",  1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h02, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
    cy("t4_load04", 1'b1, 8'h04, 1'b0, 1'b0, 1'b0, 8'h04, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cy("t4_start",  1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h04, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    seg("t4_04_03", 8'h04, 1'b0, 8'h03, 1'b1);
    cy("t4_pen03",  1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
    cy("t4_load20", 1'b1, 8'h20, 1'b0, 1'b0, 1'b0, 8'h20, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cy("t4_penidl", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h20, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cy("t4_start",  1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h20, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cy("t4_wait", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h20, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    end
    cy("t4_pentck", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h14, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    cy("t4_pause",  1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h14, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cy("t4_penpau", 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 8'h09, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // 5: clamped loads, load during RUN clears prescaler, start+pause in PAUSED
    cy("t5_load9F", 1'b1, 8'h9F, 1'b0, 1'b0, 1'b0, 8'h99, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cy("t5_load5C", 1'b1, 8'h5C, 1'b0, 1'b0, 1'b0, 8'h59, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cy("t5_start",  1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h59, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cy("t5_p1",     1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h59, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cy("t5_p2",     1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h59, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cy("t5_loadrun",1'b1, 8'h45, 1'b0, 1'b0, 1'b0, 8'h45, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cy("t5_start",  1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h45, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    seg("t5_45_44", 8'h45, 1'b0, 8'h44, 1'b0);
    cy("t5_pause",  1'b0, 8'h00, 1'b0, 1'b1, 1'b0, 8'h44, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cy("t5_stpau",  1'b0, 8'h00, 1'b1, 1'b1, 1'b0, 8'h44, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cy("t5_hold",   1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h44, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // 6: reset mid-RUN, then start with count 0 is ignored
    cy("t6_load",  1'b1, 8'h11, 1'b0, 1'b0, 1'b0, 8'h11, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    cy("t6_start", 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    cy("t6_run",   1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b0;
    cy("t6_reset", 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset_n = 1'b1;
    cy("t6_start0",1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // Drain: every queued expectation must have been consumed
    start = 1'b0;
    repeat (3) @(negedge clk);
    if (sb_q.size() != 0) begin
      n_checks = n_checks + 1;
      n_err    = n_err + 1;
      $display("FAIL drain: %0d expectations left, want 0", sb_q.size());
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
